// File: rtl/me_double.sv
// Full-search block-matching motion estimator: 16x16 template over a 64x64 window, 4 candidates per pass.
// Build option ME_DOUBLE_TIE_LAST_EN: ties resolve to the last equal candidate in scan order instead of the first.
module me_double (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic [15:0] min_sad,
  output logic [9:0]  min_mvec,
  output logic        ack,
  input  logic [31:0] pel_sw,
  input  logic [31:0] pel_tb,
  output logic [9:0]  addr_sw,
  output logic [5:0]  addr_tb
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;

  logic [4:0]  h_q;
  logic [2:0]  k_q;
  logic [3:0]  r_q;
  logic [2:0]  t_q;
  logic        iss_end_q;
  logic        start, issue;

  logic        d_vld_q, d_last_q, d_final_q;
  logic [2:0]  d_t_q, d_k_q;
  logic [4:0]  d_h_q;

  logic [31:0] sw_prev_q, tb_prev_q;
  logic [15:0] acc_q [4];
  logic [15:0] fin_q [4];
  logic        f_vld_q, f_final_q;
  logic [4:0]  f_h_q;
  logic [2:0]  f_k_q;

  logic [15:0] best_q, best_d;
  logic [9:0]  bmv_q, bmv_d;
  logic        first_q, first_d;

  logic [7:0]  pix  [8];
  logic [7:0]  tpix [4];
  logic [9:0]  part [4];

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = RUN;
      RUN:     if (f_vld_q && f_final_q) state_d = DONE;
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ack   = (state_q == DONE);
    start = (state_q == IDLE) && req;
    issue = (state_q == RUN) && !iss_end_q;
  end

  // Scan counters: t = word within row, r = template row, k = column group, h = row offset
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      h_q <= '0; k_q <= '0; r_q <= '0; t_q <= '0; iss_end_q <= 1'b0;
    end else if (issue) begin
      if (t_q == 3'd4) begin
        t_q <= '0;
        r_q <= r_q + 4'd1;
        if (r_q == 4'd15) begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            h_q <= h_q + 5'd1;
            if (h_q == 5'd31) iss_end_q <= 1'b1;
          end
        end
      end else begin
        t_q <= t_q + 3'd1;
      end
    end
  end

  // t == 4 wraps to template word 0, whose data is never used
  assign addr_sw = {6'(h_q) + 6'(r_q), 4'(k_q) + 4'(t_q)};
  assign addr_tb = {r_q, t_q[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) d_vld_q <= 1'b0;
    else        d_vld_q <= issue;
  end

  always_ff @(posedge clk) begin
    d_t_q     <= t_q;
    d_k_q     <= k_q;
    d_h_q     <= h_q;
    d_last_q  <= (r_q == 4'd15) && (t_q == 3'd4);
    d_final_q <= (h_q == 5'd31) && (k_q == 3'd7);
  end

  // Previous sw word plus current one give 8 pixels; template word lags by one read
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      pix[i]   = sw_prev_q[31-8*i -: 8];
      pix[i+4] = pel_sw[31-8*i -: 8];
      tpix[i]  = tb_prev_q[31-8*i -: 8];
    end
    for (int unsigned o = 0; o < 4; o++) begin
      part[o] = '0;
      for (int unsigned c = 0; c < 4; c++)
        part[o] = part[o] + 10'(absdiff(tpix[c], pix[o+c]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      for (int unsigned o = 0; o < 4; o++) acc_q[o] <= '0;
      f_vld_q <= 1'b0;
    end else begin
      f_vld_q <= d_vld_q && d_last_q;
      if (d_vld_q && d_t_q != 3'd0)
        for (int unsigned o = 0; o < 4; o++)
          acc_q[o] <= d_last_q ? '0 : acc_q[o] + 16'(part[o]);
    end
  end

  always_ff @(posedge clk) begin
    if (d_vld_q) begin
      sw_prev_q <= pel_sw;
      tb_prev_q <= pel_tb;
    end
    if (d_vld_q && d_last_q) begin
      for (int unsigned o = 0; o < 4; o++) fin_q[o] <= acc_q[o] + 16'(part[o]);
      f_h_q     <= d_h_q;
      f_k_q     <= d_k_q;
      f_final_q <= d_final_q;
    end
  end

  // Offsets 0..3 compared in scan order against the running minimum
  always_comb begin
    best_d  = best_q;
    bmv_d   = bmv_q;
    first_d = first_q;
    for (int unsigned o = 0; o < 4; o++) begin
`ifdef ME_DOUBLE_TIE_LAST_EN
      if (first_d || fin_q[o] <= best_d) begin
`else
      if (first_d || fin_q[o] < best_d) begin
`endif
        best_d  = fin_q[o];
        bmv_d   = {f_h_q, f_k_q, 2'(o)};
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      best_q  <= '1;
      bmv_q   <= '0;
      first_q <= 1'b1;
    end else if (f_vld_q) begin
      best_q  <= best_d;
      bmv_q   <= bmv_d;
      first_q <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_sad  <= '0;
      min_mvec <= '0;
    end else if (f_vld_q && f_final_q && state_q == RUN) begin
      min_sad  <= best_d;
      min_mvec <= bmv_d;
    end
  end

endmodule

// File: tb/tb_me_double.sv
// Scoreboard bench for me_double: stimulus pushes expected results, a monitor checks them on each ack rise.
module tb_me_double;

  logic        clk = 1'b0;
  logic        rst_n, req;
  logic [15:0] min_sad;
  logic [9:0]  min_mvec;
  logic        ack;
  logic [31:0] pel_sw = '0, pel_tb = '0;
  logic [9:0]  addr_sw;
  logic [5:0]  addr_tb;

  logic [31:0] sw_mem [1024];
  logic [31:0] tb_mem [64];

  int n_tests = 0;
  int n_fail  = 0;
  logic [25:0] exp_q [$];

  always #5 clk = ~clk;

  me_double dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .min_sad(min_sad), .min_mvec(min_mvec), .ack(ack),
    .pel_sw(pel_sw), .pel_tb(pel_tb),
    .addr_sw(addr_sw), .addr_tb(addr_tb)
  );

  always @(posedge clk) begin
    pel_sw <= sw_mem[addr_sw];
    pel_tb <= tb_mem[addr_tb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per ack rising edge
  initial begin
    logic ack_prev = 1'b0;
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (ack === 1'b1 && !ack_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("min_sad", 32'(min_sad), 32'(e[25:10]));
          chk("min_mvec", 32'(min_mvec), 32'(e[9:0]));
        end
      end
      ack_prev = (ack === 1'b1);
    end
  end

  function automatic logic [7:0] sw_pix(input int row, input int col);
    logic [31:0] w;
    w = sw_mem[row*16 + col/4];
    return w[31-8*(col%4) -: 8];
  endfunction

  task automatic fill(input logic [31:0] swv, input logic [31:0] tbv);
    for (int i = 0; i < 1024; i++) sw_mem[i] = swv;
    for (int i = 0; i < 64; i++)   tb_mem[i] = tbv;
  endtask

  task automatic fill_random_sw();
    for (int i = 0; i < 1024; i++) sw_mem[i] = $urandom;
  endtask

  task automatic copy_tb(input int h, input int w);
    logic [31:0] word;
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 4; j++) begin
        word = '0;
        for (int c = 0; c < 4; c++) word[31-8*c -: 8] = sw_pix(h + r, w + 4*j + c);
        tb_mem[r*4 + j] = word;
      end
  endtask

  task automatic run_search(input logic [15:0] es, input logic [9:0] em);
    int cyc;
    logic held_ok;
    exp_q.push_back({es, em});
    req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack !== 1'b1 && cyc < 20490);
    chk("ack_within_budget", 32'(ack === 1'b1), 1);
    held_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ack !== 1'b1 || min_sad !== es || min_mvec !== em) held_ok = 1'b0;
    end
    chk("done_hold_stable", 32'(held_ok), 1);
    req = 1'b0;
    @(negedge clk);
    chk("ack_fall", 32'(ack), 0);
  endtask

  initial begin
    logic idle_ok;
    rst_n = 1'b0;
    req   = 1'b0;
    fill('0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_min_sad", 32'(min_sad), 0);
    chk("rst_min_mvec", 32'(min_mvec), 0);
    chk("rst_addr_sw", 32'(addr_sw), 0);
    chk("rst_addr_tb", 32'(addr_tb), 0);
    rst_n = 1'b1;

    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (ack !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_ack_low", 32'(idle_ok), 1);

`ifdef ME_DOUBLE_TIE_LAST_EN
    run_search(16'd0, 10'h3FF);
`else
    run_search(16'd0, 10'h000);
`endif

    fill('0, 32'hFFFF_FFFF);
`ifdef ME_DOUBLE_TIE_LAST_EN
    run_search(16'd65280, 10'h3FF);
`else
    run_search(16'd65280, 10'h000);
`endif

    fill_random_sw();
    copy_tb(5, 9);
    req = 1'b1;
    repeat (100) @(negedge clk);
    chk("run_ack_low", 32'(ack), 0);
    chk("run_min_sad_hold", 32'(min_sad), 65280);
    chk("run_min_mvec_hold", 32'(min_mvec), 0);
    rst_n = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_min_sad", 32'(min_sad), 0);
    chk("abort_min_mvec", 32'(min_mvec), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_search(16'd0, {5'd5, 5'd9});

    copy_tb(12, 31);
    run_search(16'd0, {5'd12, 5'd31});

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
